// File: rtl/fib_host_if.sv
`timescale 1ns/1ps
// fib_host_if: run control, accelerator request/response and result FIFO bus
// of the Fibonacci host. The host uses the slave modport and its environment
// uses the master modport.
interface fib_host_if;
    logic        start;
    logic [7:0]  n_first;
    logic [7:0]  n_last;
    logic        busy;
    logic        done;
    logic [7:0]  req_n;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] rsp_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic        res_vld;
    logic [7:0]  res_n;
    logic [31:0] res_data;
    logic        res_pop;
    logic        mismatch;

    modport slave (
        input  start, n_first, n_last, req_rdy, rsp_data, rsp_vld, res_pop,
        output busy, done, req_n, req_vld, rsp_rdy, res_vld, res_n, res_data, mismatch
    );

    modport master (
        output start, n_first, n_last, req_rdy, rsp_data, rsp_vld, res_pop,
        input  busy, done, req_n, req_vld, rsp_rdy, res_vld, res_n, res_data, mismatch
    );
endinterface

// File: rtl/fib_host.sv
`timescale 1ns/1ps
// fib_host: walks an inclusive index range, issuing one accelerator request
// per index and storing {index, result} pairs in a first-word fall-through
// FIFO of DEPTH entries. Defining FIB_HOST_CHECK_EN compiles in a checker
// that flags results breaking the Fibonacci recurrence within a run.
module fib_host #(
    parameter int DEPTH = 4
) (
    input  logic      CLK,
    input  logic      rst_n,
    fib_host_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   LP_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cur_n;
    logic [7:0]    r_last_n;
    logic [7:0]    r_req_n;
    logic          r_busy;
    logic          r_done;
    logic          r_req_vld;
    logic          r_rsp_rdy;

    logic [39:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_res_vld;
    logic [AW:0]   w_count_nxt;
    logic          w_full_nxt;
    logic [39:0]   w_head;

    // rsp_rdy is only ever high in WAIT, so it alone qualifies a push.
    assign w_push    = (r_state == ST_WAIT) && r_rsp_rdy && bus.rsp_vld;
    assign w_res_vld = (r_count != {(AW+1){1'b0}});
    assign w_pop     = bus.res_pop && w_res_vld;
    assign w_head    = r_mem[r_rd_ptr];

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + LP_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - LP_CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
        w_full_nxt = (w_count_nxt == LP_FULL);
    end

    // Run sequencing: state, latched index range and all registered control outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cur_n   <= 8'd0;
            r_last_n  <= 8'd0;
            r_req_n   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_req_vld <= 1'b0;
            r_rsp_rdy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_cur_n  <= bus.n_first;
                        r_last_n <= bus.n_last;
                        r_busy   <= 1'b1;
                        if (bus.n_first <= bus.n_last) begin
                            r_state   <= ST_REQ;
                            r_req_vld <= 1'b1;
                            r_req_n   <= bus.n_first;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (r_req_vld && bus.req_rdy) begin
                        r_state   <= ST_WAIT;
                        r_req_vld <= 1'b0;
                        // A pop in this cycle may already free a slot.
                        r_rsp_rdy <= !w_full_nxt;
                    end
                end
                ST_WAIT: begin
                    if (w_push) begin
                        r_rsp_rdy <= 1'b0;
                        if (r_cur_n == r_last_n) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur_n   <= r_cur_n + 8'd1;
                            r_req_n   <= r_cur_n + 8'd1;
                            r_req_vld <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end else begin
                        // A pop while full only opens rsp_rdy from the next cycle.
                        r_rsp_rdy <= !w_full_nxt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_req_vld <= 1'b0;
                    r_rsp_rdy <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; contents survive across runs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage; entries are only visible through the occupancy-gated head.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_cur_n, bus.rsp_data};
        end
    end

`ifdef FIB_HOST_CHECK_EN
    logic [1:0]  r_chk_cnt;
    logic [31:0] r_prev1;
    logic [31:0] r_prev2;
    logic        r_mismatch;

    // Recurrence checker: from the third push of a run each value must equal
    // the 32-bit wrapped sum of the two before it; sticky until the next start.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_cnt  <= 2'd0;
            r_prev1    <= 32'd0;
            r_prev2    <= 32'd0;
            r_mismatch <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_chk_cnt  <= 2'd0;
            r_mismatch <= 1'b0;
        end else if (w_push) begin
            if ((r_chk_cnt == 2'd2) && (bus.rsp_data != (r_prev1 + r_prev2))) begin
                r_mismatch <= 1'b1;
            end
            if (r_chk_cnt != 2'd2) begin
                r_chk_cnt <= r_chk_cnt + 2'd1;
            end
            r_prev2 <= r_prev1;
            r_prev1 <= bus.rsp_data;
        end
    end

    assign bus.mismatch = r_mismatch;
`else
    assign bus.mismatch = 1'b0;
`endif

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.req_vld  = r_req_vld;
    assign bus.req_n    = r_req_n;
    assign bus.rsp_rdy  = r_rsp_rdy;
    assign bus.res_vld  = w_res_vld;
    assign bus.res_n    = w_res_vld ? w_head[39:32] : 8'd0;
    assign bus.res_data = w_res_vld ? w_head[31:0]  : 32'd0;
endmodule

// File: tb/tb_fib_host.sv
`timescale 1ns/1ps
// tb_fib_host: directed and randomized runs of fib_host against a behavioural
// accelerator and a result scoreboard built from Fibonacci arithmetic.
module tb_fib_host;
    localparam int DEPTH = 4;
`ifdef FIB_HOST_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fib_host_if u_if ();

    fib_host #(.DEPTH(DEPTH)) u_dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [39:0] exp_q   [$];
    logic [7:0]  exp_req [$];
    logic [7:0]  req_log [$];
    logic [31:0] ovr_q   [$];
    int          rdy_delay = 0;
    bit          rand_lat  = 1'b0;
    int          viol      = 0;
    int          done_cnt  = 0;
    bit          exp_mis   = 1'b0;

    // accelerator state
    bit          a_pend = 1'b0, a_on = 1'b0, a_hs_req = 1'b0, a_hs_rsp = 1'b0, a_prev_vld = 1'b0;
    logic [7:0]  a_pend_n = 8'd0, a_hs_n = 8'd0, a_prev_n = 8'd0;
    int          a_wait = 0, a_rdy_cnt = 0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fib(input int n);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd0;
        b = 32'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [31:0] resp_value(input logic [7:0] n);
        if (ovr_q.size() > 0) return ovr_q.pop_front();
        return fib(int'(n));
    endfunction

    // Behavioural accelerator: one request at a time, optional ready delay and
    // response latency, junk rsp_vld whenever no request is outstanding.
    initial begin : acc
        u_if.req_rdy  = 1'b0;
        u_if.rsp_vld  = 1'b0;
        u_if.rsp_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                a_pend = 1'b0; a_on = 1'b0; a_hs_req = 1'b0; a_hs_rsp = 1'b0;
                a_prev_vld = 1'b0; a_rdy_cnt = 0;
                u_if.req_rdy = 1'b0;
                u_if.rsp_vld = 1'b0;
            end else begin
                if (u_if.req_vld && u_if.rsp_rdy) viol++;
                if (u_if.req_vld && a_prev_vld && !a_hs_req)
                    check("req_n_stable", 40'(u_if.req_n), 40'(a_prev_n));
                if (a_hs_rsp) begin
                    a_pend = 1'b0;
                    a_on   = 1'b0;
                end
                if (a_hs_req) begin
                    a_pend   = 1'b1;
                    a_on     = 1'b0;
                    a_pend_n = a_hs_n;
                    req_log.push_back(a_hs_n);
                    a_wait   = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end
                if (a_pend) begin
                    if (!a_on) begin
                        if (a_wait == 0) begin
                            a_on = 1'b1;
                            u_if.rsp_data = resp_value(a_pend_n);
                        end else begin
                            a_wait--;
                            u_if.rsp_data = $urandom;
                        end
                    end
                    u_if.rsp_vld = a_on;
                end else begin
                    u_if.rsp_vld  = 1'($urandom_range(0, 1));
                    u_if.rsp_data = $urandom;
                end
                if (u_if.req_vld && !a_pend) begin
                    if (a_rdy_cnt >= rdy_delay) u_if.req_rdy = 1'b1;
                    else begin
                        u_if.req_rdy = 1'b0;
                        a_rdy_cnt++;
                    end
                end else begin
                    u_if.req_rdy = 1'b0;
                    a_rdy_cnt    = 0;
                end
                a_hs_req   = u_if.req_vld && u_if.req_rdy;
                a_hs_n     = u_if.req_n;
                a_hs_rsp   = u_if.rsp_vld && u_if.rsp_rdy && a_pend;
                a_prev_vld = u_if.req_vld;
                a_prev_n   = u_if.req_n;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     40'(u_if.busy),     40'd0);
        check({tag, "_done"},     40'(u_if.done),     40'd0);
        check({tag, "_req_vld"},  40'(u_if.req_vld),  40'd0);
        check({tag, "_req_n"},    40'(u_if.req_n),    40'd0);
        check({tag, "_rsp_rdy"},  40'(u_if.rsp_rdy),  40'd0);
        check({tag, "_res_vld"},  40'(u_if.res_vld),  40'd0);
        check({tag, "_res_n"},    40'(u_if.res_n),    40'd0);
        check({tag, "_res_data"}, 40'(u_if.res_data), 40'd0);
        check({tag, "_mismatch"}, 40'(u_if.mismatch), 40'd0);
    endtask

    // Builds the expected requests and FIFO entries, then issues start.
    task automatic start_run(input int f, input int l, input string tag);
        logic [31:0] vals [$];
        int idx;
        exp_req.delete();
        req_log.delete();
        exp_mis = 1'b0;
        idx = 0;
        for (int k = f; k <= l; k++) begin
            logic [31:0] v;
            v = (idx < ovr_q.size()) ? ovr_q[idx] : fib(k);
            vals.push_back(v);
            exp_req.push_back(8'(k));
            exp_q.push_back({8'(k), v});
            idx++;
        end
        for (int i = 2; i < vals.size(); i++)
            if (vals[i] != vals[i-1] + vals[i-2]) exp_mis = CHK_EN;
        @(negedge clk);
        u_if.start   = 1'b1;
        u_if.n_first = 8'(f);
        u_if.n_last  = 8'(l);
        @(negedge clk);
        u_if.start   = 1'b0;
        u_if.n_first = 8'($urandom);
        u_if.n_last  = 8'($urandom);
        done_cnt = int'(u_if.done);
        check({tag, "_busy_start"}, 40'(u_if.busy), 40'd1);
        check({tag, "_mis_clear"},  40'(u_if.mismatch), 40'd0);
        if (f <= l) begin
            check({tag, "_req_vld_t1"}, 40'(u_if.req_vld), 40'd1);
            check({tag, "_req_n_t1"},   40'(u_if.req_n),   40'(f));
        end else begin
            check({tag, "_done_t1"},    40'(u_if.done),    40'd1);
            check({tag, "_no_req_t1"},  40'(u_if.req_vld), 40'd0);
        end
    endtask

    task automatic pop_step(input bit pop_en, input string tag);
        if (u_if.res_vld) begin
            if (pop_en && ($urandom_range(0, 1) == 1)) begin
                u_if.res_pop = 1'b1;
                if (exp_q.size() > 0)
                    check({tag, "_head"}, {u_if.res_n, u_if.res_data}, exp_q.pop_front());
                else
                    check({tag, "_extra"}, 40'(u_if.res_vld), 40'd0);
            end else begin
                u_if.res_pop = 1'b0;
            end
        end else begin
            u_if.res_pop = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic finish_run(input bit pop_en, input string tag, output int cyc);
        bit seen;
        seen = (done_cnt > 0);
        cyc  = 0;
        while (!seen && cyc < 2000) begin
            pop_step(pop_en, tag);
            u_if.start   = 1'($urandom_range(0, 1));
            u_if.n_first = 8'($urandom);
            u_if.n_last  = 8'($urandom);
            @(negedge clk);
            cyc++;
            if (u_if.done) begin
                done_cnt++;
                seen = 1'b1;
            end
        end
        if (!seen) check({tag, "_timeout"}, 40'(u_if.done), 40'd1);
        u_if.start   = 1'b0;
        u_if.res_pop = 1'b0;
        @(negedge clk);
        if (u_if.done) done_cnt++;
        check({tag, "_done_pulses"}, 40'(done_cnt),      40'd1);
        check({tag, "_busy_end"},    40'(u_if.busy),     40'd0);
        check({tag, "_mismatch"},    40'(u_if.mismatch), 40'(exp_mis));
        ovr_q.delete();
    endtask

    task automatic check_reqs(input string tag);
        int bad;
        bad = 0;
        check({tag, "_req_count"}, 40'(req_log.size()), 40'(exp_req.size()));
        for (int i = 0; i < req_log.size() && i < exp_req.size(); i++)
            if (req_log[i] !== exp_req[i]) bad++;
        check({tag, "_req_order"}, 40'(bad), 40'd0);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (u_if.res_vld && c < 64) begin
            u_if.res_pop = 1'b1;
            if (exp_q.size() > 0)
                check({tag, "_head"}, {u_if.res_n, u_if.res_data}, exp_q.pop_front());
            else
                check({tag, "_extra"}, 40'(u_if.res_vld), 40'd0);
            @(negedge clk);
            c++;
        end
        u_if.res_pop = 1'b0;
        check({tag, "_left"},  40'(exp_q.size()), 40'd0);
        check({tag, "_empty"}, 40'(u_if.res_vld), 40'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cyc;
        int f;
        int l;
        bit hit;
        u_if.start   = 1'b0;
        u_if.n_first = 8'd0;
        u_if.n_last  = 8'd0;
        u_if.res_pop = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // ideal accelerator, 5..7: three requests, two cycles per index
        rdy_delay = 0; rand_lat = 1'b0;
        start_run(5, 7, "r5_7");
        finish_run(1'b1, "r5_7", cyc);
        check("r5_7_cycles", 40'(cyc), 40'd6);
        check_reqs("r5_7");
        drain("r5_7");

        // single index with delayed ready: req_n held, result 55
        rdy_delay = 3;
        start_run(10, 10, "r10");
        finish_run(1'b0, "r10", cyc);
        check("r10_result", {u_if.res_n, u_if.res_data}, {8'd10, 32'd55});
        check_reqs("r10");
        drain("r10");

        // empty range: no requests, immediate done
        rdy_delay = 0;
        start_run(9, 3, "r9_3");
        finish_run(1'b1, "r9_3", cyc);
        check_reqs("r9_3");

        // FIFO full back-pressure, then resume by popping
        start_run(1, 8, "full");
        u_if.res_pop = 1'b0;
        repeat (20) @(negedge clk);
        check("full_rsp_rdy",  40'(u_if.rsp_rdy), 40'd0);
        check("full_busy",     40'(u_if.busy),    40'd1);
        check("full_res_vld",  40'(u_if.res_vld), 40'd1);
        check("full_req_seen", 40'(req_log.size()), 40'(DEPTH + 1));
        finish_run(1'b1, "full", cyc);
        check_reqs("full");
        drain("full");

        // top of index range, no wrap-around
        rand_lat = 1'b1;
        start_run(253, 255, "top");
        finish_run(1'b1, "top", cyc);
        check_reqs("top");
        drain("top");

        // recurrence checker: 2,3,6,8 breaks from the third push
        rand_lat = 1'b0;
        ovr_q = '{32'd2, 32'd3, 32'd6, 32'd8};
        start_run(3, 6, "chk");
        finish_run(1'b1, "chk", cyc);
        drain("chk");
        start_run(0, 3, "chk_clr");
        finish_run(1'b1, "chk_clr", cyc);
        drain("chk_clr");

        // randomized runs; FIFO left partly filled between runs
        rand_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdy_delay = int'($urandom_range(0, 2));
            f = int'($urandom_range(1, 250));
            l = (i == 3) ? f - 1 : f + int'($urandom_range(0, 5));
            start_run(f, l, "rnd");
            finish_run(1'b1, "rnd", cyc);
            check_reqs("rnd");
            if (i % 2 == 1) drain("rnd");
        end
        drain("rnd_final");

        // reset while waiting on a response with data in the FIFO
        rdy_delay = 0; rand_lat = 1'b0;
        start_run(20, 40, "rst");
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            u_if.res_pop = 1'b0;
            @(negedge clk);
            if (u_if.rsp_rdy && u_if.res_vld) hit = 1'b1;
        end
        check("rst_reach_wait", 40'(hit), 40'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_after_done", 40'(u_if.done),    40'd0);
            check("rst_after_busy", 40'(u_if.busy),    40'd0);
            check("rst_after_fifo", 40'(u_if.res_vld), 40'd0);
        end

        // recovery run after reset
        start_run(0, 2, "post");
        finish_run(1'b1, "post", cyc);
        check_reqs("post");
        drain("post");

        check("req_rsp_exclusive", 40'(viol), 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
